// File: rtl/cgra_clock_gate_pkg.sv
// Shared types and constants for the CGRA column clock-gate controller.
package cgra_clock_gate_pkg;

  // Width of the per-column wake settle counter (WAKE_CYCLES is limited to 0..7).
  localparam int WAKE_CNT_W = 3;

  // Per-column gating state.
  typedef enum logic [1:0] {
    GATED  = 2'd0,
    WAKING = 2'd1,
    ACTIVE = 2'd2
  } col_state_t;

  // Value loaded into the wake counter when a column starts waking.
  // The counter reaches zero on the edge before the column becomes ready.
  function automatic logic [WAKE_CNT_W-1:0] wake_load(input int cycles);
    if (cycles > 0) begin
      return WAKE_CNT_W'(cycles - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/cgra_clock_gate_col_fsm.sv
// One CGRA column's gating FSM: wakes on request, reports ready after the
// settle delay, and gates again after a run of consecutive idle cycles.
module cgra_clock_gate_col_fsm
  import cgra_clock_gate_pkg::*;
#(
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDLE_W-1:0] cfg_idle_thresh_i,
  input  logic              req_i,
  input  logic              busy_i,
  output logic              en_o,
  output logic              ready_o
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = wake_load(WAKE_CYCLES);

  col_state_t            state_q, state_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic                  en_q, en_d;
  logic                  ready_q, ready_d;
  logic                  idle;
  logic [IDLE_W:0]       idle_next;

  // Next-state, counter and output decode; outputs follow the next state so
  // that en/ready are flops and never glitch into the clock-gating cell.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    idle       = !req_i && !busy_i;
    idle_next  = {1'b0, idle_cnt_q} + (IDLE_W+1)'(1);

    case (state_q)
      GATED: begin
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        if (req_i) begin
          if (WAKE_CYCLES == 0) begin
            state_d = ACTIVE;
          end else begin
            state_d    = WAKING;
            wake_cnt_d = WAKE_LOAD;
          end
        end
      end
      WAKING: begin
        idle_cnt_d = '0;
        if (wake_cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          wake_cnt_d = wake_cnt_q - WAKE_CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (idle) begin
          if ((cfg_idle_thresh_i != '0) && (idle_next >= {1'b0, cfg_idle_thresh_i})) begin
            state_d    = GATED;
            idle_cnt_d = '0;
          end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = GATED;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase

    en_d    = (state_d != GATED);
    ready_d = (state_d == ACTIVE);
  end

  // State, counters and registered outputs; reset drops the column straight to GATED.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= GATED;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      en_q       <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      en_q       <= en_d;
      ready_q    <= ready_d;
    end
  end

  assign en_o    = en_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/cgra_clock_gate_ctrl.sv
// Per-column clock-gate enable generator for the CGRA: one independent
// gating FSM per column plus a global force-on override for test/debug.
module cgra_clock_gate_ctrl
  import cgra_clock_gate_pkg::*;
#(
  parameter int N_COL       = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDLE_W-1:0] cfg_idle_thresh_i,
  input  logic              force_on_i,
  input  logic [N_COL-1:0]  req_i,
  input  logic [N_COL-1:0]  busy_i,
  output logic [N_COL-1:0]  clk_en_o,
  output logic [N_COL-1:0]  ready_o
);

  logic [N_COL-1:0] en_q;

  // Columns share nothing but the clock, reset and idle threshold.
  for (genvar c = 0; c < N_COL; c++) begin : g_col
    cgra_clock_gate_col_fsm #(
      .IDLE_W      (IDLE_W),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_col_fsm (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .cfg_idle_thresh_i (cfg_idle_thresh_i),
      .req_i             (req_i[c]),
      .busy_i            (busy_i[c]),
      .en_o              (en_q[c]),
      .ready_o           (ready_o[c])
    );
  end

  // Force-on only widens the enables; FSM state and ready are untouched.
  assign clk_en_o = en_q | {N_COL{force_on_i}};

endmodule
